// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StRun   = 2'd1,
        StFault = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous {pc, inst} buffer between the fetch stage and decode, with flush and occupancy count.
module fetch_unit_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                         i_clk,
    input  logic                         rst_n,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  fetch_entry_t                 i_wdata,
    input  logic                         i_pop,
    output fetch_entry_t                 o_rdata,
    output logic                         o_empty,
    output logic [$clog2(Depth+1)-1:0]   o_count
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    fetch_entry_t    mem_q [Depth];
    fetch_entry_t    mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign full    = cnt_q == CntW'(Depth);
    assign o_empty = cnt_q == '0;
    assign o_count = cnt_q;
    assign o_rdata = mem_q[rd_ptr_q];
    assign do_push = i_push && (!full || i_pop);
    assign do_pop  = i_pop && !o_empty;

    // Depth is a power of two, so pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = i_wdata;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_d = cnt_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited pipelined imem requests, buffers
// responses toward decode and drops responses made stale by redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP        = NOP_INST
) (
    input  logic        i_clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_misaligned
);
    localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CreditW = CntW + 1;
    localparam logic [CreditW-1:0] Credit = CreditW'(FIFO_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [CntW-1:0] outs_q, outs_d;
    logic [CntW-1:0] disc_q, disc_d;
    logic [31:0]     pend_q [FIFO_DEPTH];
    logic [31:0]     pend_d [FIFO_DEPTH];
    logic [PtrW-1:0] pend_wr_q, pend_wr_d;
    logic [PtrW-1:0] pend_rd_q, pend_rd_d;

    logic            grant;
    logic            rsp_any;
    logic            rsp_live;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;
    fetch_entry_t    fifo_wdata;
    fetch_entry_t    fifo_head;

    // Outstanding includes discarded requests, so a response always finds FIFO space.
    assign o_imem_req  = (state_q == StRun) &&
                         (({1'b0, outs_q} + {1'b0, fifo_count}) < Credit);
    assign o_imem_addr = {pc_q[31:2], 2'b00};
    assign grant       = o_imem_req && i_imem_gnt;
    assign rsp_any     = i_imem_rvalid && (outs_q != '0);
    assign rsp_live    = rsp_any && (disc_q == '0);
    assign fifo_push   = rsp_live && !i_redirect;
    assign fifo_pop    = (state_q == StRun) && !fifo_empty && i_ready;
    assign fifo_wdata  = '{pc: pend_q[pend_rd_q], inst: i_imem_rdata};

    fetch_unit_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .rst_n   (rst_n),
        .i_flush (i_redirect),
        .i_push  (fifo_push),
        .i_wdata (fifo_wdata),
        .i_pop   (fifo_pop),
        .o_rdata (fifo_head),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        outs_d    = outs_q;
        disc_d    = disc_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        pend_rd_d = pend_rd_q;

        unique case (state_q)
            StBoot:         state_d = StRun;
            StRun, StFault: state_d = state_q;
            default:        state_d = StBoot;
        endcase

        if (grant) begin
            pc_d              = pc_q + 32'd4;
            outs_d            = outs_d + CntW'(1);
            pend_d[pend_wr_q] = pc_q;
            pend_wr_d         = pend_wr_q + PtrW'(1);
        end
        if (rsp_any) begin
            outs_d = outs_d - CntW'(1);
        end
        if (rsp_live) begin
            pend_rd_d = pend_rd_q + PtrW'(1);
        end else if (rsp_any) begin
            disc_d = disc_q - CntW'(1);
        end

        // Everything still in flight after this cycle becomes stale.
        if (i_redirect) begin
            pc_d      = i_redirect_pc;
            state_d   = is_misaligned(i_redirect_pc) ? StFault : StRun;
            disc_d    = outs_d;
            pend_wr_d = '0;
            pend_rd_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StBoot;
            pc_q      <= RESET_PC;
            outs_q    <= '0;
            disc_q    <= '0;
            pend_wr_q <= '0;
            pend_rd_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            outs_q    <= outs_d;
            disc_q    <= disc_d;
            pend_wr_q <= pend_wr_d;
            pend_rd_q <= pend_rd_d;
        end
    end

    always_ff @(posedge i_clk) begin
        pend_q <= pend_d;
    end

    always_comb begin
        o_misaligned = 1'b0;
        o_valid      = !fifo_empty;
        o_inst       = fifo_empty ? NOP : fifo_head.inst;
        o_pc         = fifo_empty ? pc_q : fifo_head.pc;
        if (state_q == StFault) begin
            o_misaligned = 1'b1;
            o_valid      = 1'b1;
            o_inst       = NOP;
            o_pc         = pc_q;
        end
    end

    // Leftover responses from before a reset may still land during BOOT.
    rsp_protocol_a: assert property (@(posedge i_clk) disable iff (!rst_n)
        (i_imem_rvalid && state_q != StBoot) |-> (outs_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: an imem model answers grants, a monitor checks decode output.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int unsigned Depth = 2;
    localparam logic [31:0] Nop   = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_ready;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_misaligned;

    always #5 i_clk = ~i_clk;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (Depth),
        .NOP        (Nop)
    ) dut (
        .i_clk         (i_clk),
        .rst_n         (rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_ready       (i_ready),
        .o_valid       (o_valid),
        .o_inst        (o_inst),
        .o_pc          (o_pc),
        .o_misaligned  (o_misaligned)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          budget = 0;
    int          grants = 0;
    int          pops = 0;
    int          lat_max = 1;
    bit          lat_rand = 1'b0;
    bit          gnt_rand = 1'b0;
    bit          stale_req = 1'b0;
    bit          sb_en = 1'b1;
    logic [31:0] exp_addr = 32'h0;
    logic [63:0] sb_q [$];
    logic [31:0] mq_addr [$];
    int          mq_due [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge i_clk);
            #2;
        end
    endtask

    task automatic expect_seq(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            sb_q.push_back({base + 32'(4 * k), mem_word(base + 32'(4 * k))});
        end
    endtask

    task automatic drain(input string name, input bit rand_ready);
        int t;
        t = 0;
        while ((sb_q.size() != 0 || mq_due.size() != 0 || budget != 0) && t < 600) begin
            i_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            t++;
        end
        i_ready = 1'b1;
        checks++;
        if (t >= 600) begin
            errors++;
            $display("FAIL %s_drain: %0d outputs still expected after %0d cycles, need 0",
                     name, sb_q.size(), t);
        end
    endtask

    task automatic redirect(input logic [31:0] pc);
        i_redirect    = 1'b1;
        i_redirect_pc = pc;
        tick();
        i_redirect    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check32({name, "_req"}, 32'(o_imem_req), 32'd0);
        check32({name, "_addr"}, o_imem_addr, 32'h0);
        check32({name, "_valid"}, 32'(o_valid), 32'd0);
        check32({name, "_inst"}, o_inst, Nop);
        check32({name, "_pc"}, o_pc, 32'h0);
        check32({name, "_misaligned"}, 32'(o_misaligned), 32'd0);
    endtask

    // Instruction memory: in-order responses, latency 1..lat_max after the grant edge.
    initial begin : mem_model
        int last_due;
        int due;
        last_due      = 0;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = '0;
        forever begin
            @(posedge i_clk);
            #3;
            cyc++;
            i_imem_gnt    = 1'b0;
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = '0;
            if (!rst_n || stale_req) begin
                mq_addr.delete();
                mq_due.delete();
                last_due = cyc;
                if (stale_req) begin
                    i_imem_rvalid = 1'b1;
                    i_imem_rdata  = 32'hDEAD_BEEF;
                end
            end else begin
                if (mq_due.size() != 0 && mq_due[0] <= cyc) begin
                    i_imem_rvalid = 1'b1;
                    i_imem_rdata  = mem_word(mq_addr.pop_front());
                    void'(mq_due.pop_front());
                end
                if (budget > 0 && (!gnt_rand || $urandom_range(0, 1) == 1)) begin
                    i_imem_gnt = 1'b1;
                end
                if (i_imem_gnt && o_imem_req) begin
                    check32("grant_addr", o_imem_addr, exp_addr);
                    due = cyc + (lat_rand ? int'($urandom_range(1, lat_max)) : lat_max);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    mq_addr.push_back(o_imem_addr);
                    mq_due.push_back(due);
                    exp_addr = exp_addr + 32'd4;
                    budget--;
                    grants++;
                end
            end
        end
    end

    initial begin : monitor
        logic [63:0] ent;
        forever begin
            @(negedge i_clk);
            if (rst_n && o_valid && i_ready && !o_misaligned) begin
                pops++;
                if (sb_en) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got pc %h inst %h, expected none",
                                 o_pc, o_inst);
                    end else begin
                        ent = sb_q.pop_front();
                        check32("dec_pc", o_pc, ent[63:32]);
                        check32("dec_inst", o_inst, ent[31:0]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : main
        int          t;
        int          g0;
        int          p0;
        bit          have;
        logic [31:0] frz_pc;
        logic [31:0] frz_inst;

        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_ready       = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        tick(2);

        // Test 1: streaming fetch from RESET_PC.
        rst_n    = 1'b1;
        exp_addr = 32'h0;
        budget   = 8;
        expect_seq(32'h0, 8);
        check32("boot_req", 32'(o_imem_req), 32'd0);
        t = 0;
        while (!o_imem_req && t < 10) begin
            tick();
            t++;
        end
        check32("first_req_seen", 32'(o_imem_req), 32'd1);
        tick();
        check32("valid_after_grant", 32'(o_valid), 32'd0);
        tick();
        check32("valid_2_after_grant", 32'(o_valid), 32'd1);
        check32("first_pc", o_pc, 32'h0);
        drain("t1", 1'b0);

        // Test 2: decode stalls; credit bound and stable outputs.
        i_ready = 1'b0;
        g0      = grants;
        p0      = pops;
        have    = 1'b0;
        budget  = 6;
        expect_seq(32'h20, 6);
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ((grants - g0) - (pops - p0) > Depth) begin
                errors++;
                $display("FAIL stall_credit: got %0d in flight, expected at most %0d",
                         (grants - g0) - (pops - p0), Depth);
            end
            if (o_valid) begin
                if (!have) begin
                    have     = 1'b1;
                    frz_pc   = o_pc;
                    frz_inst = o_inst;
                end else begin
                    check32("stall_pc_hold", o_pc, frz_pc);
                    check32("stall_inst_hold", o_inst, frz_inst);
                end
            end
        end
        check32("stall_valid_seen", 32'(have), 32'd1);
        check32("stall_head_pc", frz_pc, 32'h20);
        drain("t2", 1'b0);

        // Test 3: redirect with two requests in flight.
        lat_rand = 1'b0;
        lat_max  = 4;
        g0       = grants;
        budget   = 2;
        t        = 0;
        while (grants < g0 + 2 && t < 20) begin
            tick();
            t++;
        end
        check32("t3_two_in_flight", 32'(mq_due.size()), 32'd2);
        redirect(32'h100);
        check32("t3_flush_valid", 32'(o_valid), 32'd0);
        exp_addr = 32'h100;
        budget   = 2;
        expect_seq(32'h100, 2);
        drain("t3", 1'b0);
        lat_max = 1;

        // Test 4: misaligned redirect target and recovery.
        redirect(32'h102);
        check32("fault_valid", 32'(o_valid), 32'd1);
        check32("fault_misaligned", 32'(o_misaligned), 32'd1);
        check32("fault_pc", o_pc, 32'h102);
        check32("fault_inst", o_inst, Nop);
        check32("fault_req", 32'(o_imem_req), 32'd0);
        i_ready = 1'b0;
        tick(3);
        check32("fault_hold_pc", o_pc, 32'h102);
        check32("fault_hold_valid", 32'(o_valid), 32'd1);
        i_ready = 1'b1;
        tick(2);
        check32("fault_hold_rdy_pc", o_pc, 32'h102);
        redirect(32'h106);
        check32("fault_retarget_pc", o_pc, 32'h106);
        check32("fault_retarget_mis", 32'(o_misaligned), 32'd1);
        redirect(32'h200);
        check32("fault_exit_mis", 32'(o_misaligned), 32'd0);
        exp_addr = 32'h200;
        budget   = 3;
        expect_seq(32'h200, 3);
        drain("t4", 1'b0);

        // Test 5: random grant and latency, random decode backpressure.
        redirect(32'h300);
        exp_addr = 32'h300;
        gnt_rand = 1'b1;
        lat_rand = 1'b1;
        lat_max  = 4;
        budget   = 20;
        expect_seq(32'h300, 20);
        drain("t5", 1'b1);

        // Test 6: reset mid-burst, stale response during reset and BOOT.
        sb_en    = 1'b0;
        gnt_rand = 1'b0;
        lat_rand = 1'b0;
        lat_max  = 2;
        budget   = 10;
        tick(4);
        rst_n     = 1'b0;
        budget    = 0;
        stale_req = 1'b1;
        #1 check_reset_outputs("midreset");
        tick(2);
        rst_n = 1'b1;
        tick();
        stale_req = 1'b0;
        check32("post_reset_valid", 32'(o_valid), 32'd0);
        check32("post_reset_addr", o_imem_addr, 32'h0);
        sb_q.delete();
        sb_en    = 1'b1;
        exp_addr = 32'h0;
        budget   = 3;
        expect_seq(32'h0, 3);
        drain("t6", 1'b0);

        tick(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
